fc_layer_stream: RTL

- Parametrised successor to the combinational fully-connected PE array.
- Holds NUM_PE accumulating lanes, one per output neuron. Each lane computes bias + sum over IN_LEN of x[k]*w[k] in signed fixed point.
- Inputs stream in one element per beat over a valid/ready handshake. The block sequences the whole dot product itself with a counter and FSM, then applies optional ReLU, rounding and saturation.
- Results are presented on a valid/ready output port. Sits between the weight-cache reader and the next layer / softmax stage.

---
 rtl/fc_pkg.sv | 28 ++
 rtl/fc_mac_lane.sv | 69 ++++++
 rtl/fc_layer_stream.sv | 101 ++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// Shared constants, FSM encoding and saturation bounds for the streaming
// fully-connected layer and its MAC lanes.
package fc_pkg;

   typedef logic [1:0] fc_state_t;

   localparam fc_state_t ST_IDLE  = 2'd0;
   localparam fc_state_t ST_ACCUM = 2'd1;
   localparam fc_state_t ST_FINAL = 2'd2;
   localparam fc_state_t ST_HOLD  = 2'd3;

   function automatic int prod_width(input int dw);
      return 2 * dw;
   endfunction

   function automatic int cnt_width(input int in_len);
      return $clog2(in_len + 1);
   endfunction

   function automatic longint sat_max(input int dw);
      return (64'sd1 <<< (dw - 1)) - 64'sd1;
   endfunction

   function automatic longint sat_min(input int dw);
      return -(64'sd1 <<< (dw - 1));
   endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One output neuron: bias preload, signed multiply-accumulate, then
// round-half-up, optional ReLU and saturation into a registered result.
module fc_mac_lane
   import fc_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_WIDTH = 8,
   parameter int ACC_WIDTH  = 40
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         i_load,
   input  logic                         i_acc_en,
   input  logic                         i_final_en,
   input  logic                         i_relu,
   input  logic signed [DATA_WIDTH-1:0] i_bias,
   input  logic signed [DATA_WIDTH-1:0] i_data,
   input  logic signed [DATA_WIDTH-1:0] i_weight,
   output logic        [DATA_WIDTH-1:0] o_result
);

   localparam int PROD_WIDTH = prod_width(DATA_WIDTH);
   localparam logic signed [ACC_WIDTH-1:0] SAT_HI   = ACC_WIDTH'(sat_max(DATA_WIDTH));
   localparam logic signed [ACC_WIDTH-1:0] SAT_LO   = ACC_WIDTH'(sat_min(DATA_WIDTH));
   localparam logic signed [ACC_WIDTH-1:0] HALF_LSB = ACC_WIDTH'(64'sd1 <<< (FRAC_WIDTH - 1));

   logic signed [ACC_WIDTH-1:0]  r_acc;
   logic        [DATA_WIDTH-1:0] r_out;
   logic signed [PROD_WIDTH-1:0] w_prod;
   logic signed [ACC_WIDTH-1:0]  w_prod_ext;
   logic signed [ACC_WIDTH-1:0]  w_bias_ext;
   logic signed [ACC_WIDTH-1:0]  w_rounded;
   logic signed [ACC_WIDTH-1:0]  w_shifted;
   logic        [DATA_WIDTH-1:0] w_clamped;

   assign w_prod     = i_data * i_weight;
   assign w_prod_ext = ACC_WIDTH'(w_prod);
   assign w_bias_ext = ACC_WIDTH'(i_bias) <<< FRAC_WIDTH;
   assign w_rounded  = r_acc + HALF_LSB;
   assign w_shifted  = w_rounded >>> FRAC_WIDTH;

   // ReLU takes priority so a clamped negative never reaches the low bound
   always_comb begin
      w_clamped = w_shifted[DATA_WIDTH-1:0];
      if (i_relu && (w_shifted < 0))
         w_clamped = '0;
      else if (w_shifted > SAT_HI)
         w_clamped = DATA_WIDTH'(SAT_HI);
      else if (w_shifted < SAT_LO)
         w_clamped = DATA_WIDTH'(SAT_LO);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc <= '0;
         r_out <= '0;
      end else begin
         if (i_load)
            r_acc <= w_bias_ext;
         else if (i_acc_en)
            r_acc <= r_acc + w_prod_ext;
         if (i_final_en)
            r_out <= w_clamped;
      end
   end

   assign o_result = r_out;

endmodule

// File: rtl/fc_layer_stream.sv
// Streaming fully-connected layer: NUM_PE lanes consume IN_LEN beats per pass.
//   state | meaning
//   IDLE  | waiting for start; bias and relu_en sampled here
//   ACCUM | accepting beats until IN_LEN have been consumed
//   FINAL | round/ReLU/saturate into the output register
//   HOLD  | result presented until out_ready
module fc_layer_stream
   import fc_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_WIDTH = 8,
   parameter int NUM_PE     = 8,
   parameter int IN_LEN     = 64,
   parameter int ACC_WIDTH  = 40
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         relu_en,
   input  logic [NUM_PE*DATA_WIDTH-1:0] bias,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_WIDTH-1:0]        in_data,
   input  logic [NUM_PE*DATA_WIDTH-1:0] in_weights,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [NUM_PE*DATA_WIDTH-1:0] out_data,
   output logic                         busy
);

   localparam int CNT_WIDTH = cnt_width(IN_LEN);
   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(IN_LEN - 1);

   fc_state_t            r_state;
   fc_state_t            w_next;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic                 r_relu;
   logic                 w_accept;
   logic                 w_load;
   logic                 w_final;

   assign w_accept = in_valid && in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_next = ST_ACCUM;
         ST_ACCUM: if (w_accept && (r_cnt == LAST_CNT)) w_next = ST_FINAL;
         ST_FINAL: w_next = ST_HOLD;
         ST_HOLD:  if (out_ready) w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == ST_ACCUM);
      out_valid = (r_state == ST_HOLD);
      busy      = (r_state != ST_IDLE);
      w_load    = (r_state == ST_IDLE) && start;
      w_final   = (r_state == ST_FINAL);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt  <= '0;
         r_relu <= 1'b0;
      end else if (w_load) begin
         r_cnt  <= '0;
         r_relu <= relu_en;
      end else if (w_accept) begin
         r_cnt  <= r_cnt + 1'b1;
      end
   end

   for (genvar g = 0; g < NUM_PE; g++) begin : g_lane
      fc_mac_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .FRAC_WIDTH (FRAC_WIDTH),
         .ACC_WIDTH  (ACC_WIDTH)
      ) u_lane (
         .clk        (clk),
         .reset      (reset),
         .i_load     (w_load),
         .i_acc_en   (w_accept),
         .i_final_en (w_final),
         .i_relu     (r_relu),
         .i_bias     (bias[g*DATA_WIDTH +: DATA_WIDTH]),
         .i_data     (in_data),
         .i_weight   (in_weights[g*DATA_WIDTH +: DATA_WIDTH]),
         .o_result   (out_data[g*DATA_WIDTH +: DATA_WIDTH])
      );
   end

endmodule
